multi_bounded_counter: RTL and testbench
========================================

# multi_bounded_counter

Multi-channel, clock-synchronous successor to the single-channel event bound counter. Each channel counts rising edges of its own event input and compares the count against a runtime-programmable bound. On reaching the bound, a channel either wraps to zero or stops and holds. The block sits between raw pulse sources (PWM edges, encoder ticks, sensor strobes) and control logic that needs "N events elapsed" notifications, and runs in the main `clk` domain.

## Interface
- `N`, 8: count and bound width per channel; must be ≥ 2.
- `NUM_CH`, 4: number of independent channels; must be ≥ 1.
- `WRAP_ON_BOUND`, 1: 1 = count returns to 0 on reaching the bound; 0 = count stops at the bound until cleared.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `event_in`  in  NUM_CH  raw event level per channel; one count per rising edge.
- `enable`  in  NUM_CH  per-channel count enable; edges seen while low are discarded, not deferred.
- `clear`  in  NUM_CH  per-channel synchronous clear.
- `bound`  in  NUM_CH*N  per-channel bound; channel i is `bound[i*N +: N]`. Sampled every cycle.
- `count`  out  NUM_CH*N  per-channel registered count; channel i is `count[i*N +: N]`.
- `bound_reached`  out  NUM_CH  registered one-cycle pulse per channel.
- `stopped`  out  NUM_CH  per-channel level; high while the channel is halted at its bound (only when `WRAP_ON_BOUND`=0).

## Operation
- **Reset values:** `count`=0, `bound_reached`=0, `stopped`=0, edge-history flop=1.
  - Because the history flop resets to 1, an input held high through reset release is not counted.
- **Edge detect:** `rise[i] = ev[i] & ~ev_prev[i]`.
  - `ev` is `event_in`, or its synchronised copy when synchronisation is compiled in.
  - `ev_prev` is registered every cycle, independent of `enable`.
- **Increment condition:** `rise & enable & ~stopped & (bound != 0)`.
  - `next = count + 1`, computed N+1 bits wide.
  - `hit = (next >= bound)`. This uses ≥, not ==, so lowering `bound` below the current count still terminates.
- **On increment with `hit`=0:** `count ← next`.
- **On increment with `hit`=1:**
  - `bound_reached ← 1` for exactly one cycle.
  - If `WRAP_ON_BOUND`=1: `count ← 0`.
  - If `WRAP_ON_BOUND`=0: `count ← bound` and `stopped ← 1`.
- **Overflow:** `next` cannot exceed 2^N, since `bound` ≤ 2^N−1 forces `hit` first. Count never wraps modulo 2^N.
- **Bound = 0:** the channel never increments and never pulses. `count` holds, and a previously set `stopped` holds.
- **Clear priority:** `clear` beats increment in the same cycle.
  - Sets `count ← 0` and `stopped ← 0`.
  - Suppresses `bound_reached` for that cycle.
  - Does not touch `ev_prev`, so an edge coinciding with `clear` is lost.
- **Channel independence:** channels are fully independent; simultaneous hits on several channels each pulse in the same cycle.
- **Per-channel state:** `IDLE/COUNTING` (`stopped`=0) → `HALTED` (`stopped`=1, stop mode only) → back to `COUNTING` on `clear` or `reset`.
- **Reset mid-operation:** asynchronous. All outputs go to their reset values immediately, regardless of `clk`.

## Timing
- **Without synchroniser:** `event_in` first sampled high at edge k (low at edge k−1) → `count` updated after edge k. `bound_reached` is high from edge k to edge k+1. Latency is 1 edge.
- **With synchroniser:** the same quantities are observed after edge k+2.
- **Minimum event spacing:** high ≥ 1 `clk` period and low ≥ 1 `clk` period between edges; narrower pulses may be missed.
- **`clear`, `enable`, `bound`:** take effect at the edge that samples them.
- **`stopped`:** rises at the same edge that pulses `bound_reached`.

## Configuration
- **Macro:** `MULTI_BOUNDED_COUNTER_INPUT_SYNC_EN`.
- **Defined:** each `event_in` bit passes through a two-flop synchroniser (both flops reset to 1) before edge detection. This is for asynchronous pulse sources and adds 2 cycles of latency.
- **Undefined:** `event_in` feeds edge detection directly. Inputs must already be synchronous to `clk`.

## Test plan
- **Wrap mode:** `NUM_CH`=2, `WRAP_ON_BOUND`=1, ch0 `bound`=3, 7 edges → ch0 count 1,2,0,1,2,0,1; `bound_reached` pulses after edges 3 and 6; ch1 is unaffected.
- **Stop mode:** `WRAP_ON_BOUND`=0, `bound`=5, 8 edges → count stops at 5; `stopped`=1 after edge 5; one pulse only. Then `clear` → count 0, `stopped`=0; the next edge → count 1.
- **Bound lowered:** count=6, `bound` changed to 4, one edge → `hit`, pulse. Wrap mode: count 0. Stop mode: count 4.
- **Corner inputs:**
  - `bound`=0 with 10 edges → count stays 0, no pulse.
  - `enable`=0 during 3 edges → no change.
  - `N`=8 with `bound`=255 → pulse on edge 255; count never wraps past 255.
- **Simultaneous events:** `clear` coincides with the edge that would hit → count 0, no pulse.
- **Reset:** `reset` asserted mid-count (count=3) between clock edges → all outputs 0 immediately. `event_in` held high across reset release → not counted.
- **Synchroniser build:** with `MULTI_BOUNDED_COUNTER_INPUT_SYNC_EN` defined → every count and pulse update lands 2 cycles later than in the undefined build.

Source files
------------

// File: rtl/multi_bounded_counter.sv
// multi_bounded_counter: per-channel event counters with programmable wrap/stop bound; optional input synchroniser via MULTI_BOUNDED_COUNTER_INPUT_SYNC_EN
module multi_bounded_counter #(
  parameter int N = 8,
  parameter int NUM_CH = 4,
  parameter int WRAP_ON_BOUND = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   event_in,
  input  logic [NUM_CH-1:0]   enable,
  input  logic [NUM_CH-1:0]   clear,
  input  logic [NUM_CH*N-1:0] bound,
  output logic [NUM_CH*N-1:0] count,
  output logic [NUM_CH-1:0]   bound_reached,
  output logic [NUM_CH-1:0]   stopped
);
  logic [NUM_CH-1:0] w_ev;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] r_prev;
`ifdef MULTI_BOUNDED_COUNTER_INPUT_SYNC_EN
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  // two-flop synchroniser; resets high so a level held through reset is not seen as an edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= event_in;
      r_sync2 <= r_sync1;
    end
  assign w_ev = r_sync2;
`else
  assign w_ev = event_in;
`endif
  // edge history, updated every cycle regardless of enable or clear
  always_ff @(posedge clk or posedge reset)
    if (reset) r_prev <= '1;
    else r_prev <= w_ev;
  assign w_rise = w_ev & ~r_prev;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [N-1:0] r_cnt;
    logic         r_pls;
    logic         r_stp;
    logic [N-1:0] w_bnd;
    logic [N:0]   w_next;
    logic         w_hit;
    logic         w_inc;
    assign w_bnd  = bound[g*N +: N];
    assign w_next = {1'b0, r_cnt} + (N+1)'(1);
    assign w_hit  = w_next >= {1'b0, w_bnd};
    assign w_inc  = w_rise[g] & enable[g] & ~r_stp & (|w_bnd);
    // count/pulse/halt update; clear wins over an increment in the same cycle
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        r_cnt <= '0;
        r_pls <= 1'b0;
        r_stp <= 1'b0;
      end else if (clear[g]) begin
        r_cnt <= '0;
        r_pls <= 1'b0;
        r_stp <= 1'b0;
      end else if (w_inc && w_hit) begin
        r_cnt <= (WRAP_ON_BOUND != 0) ? '0 : w_bnd;
        r_pls <= 1'b1;
        r_stp <= (WRAP_ON_BOUND == 0);
      end else if (w_inc) begin
        r_cnt <= w_next[N-1:0];
        r_pls <= 1'b0;
      end else
        r_pls <= 1'b0;
    assign count[g*N +: N]  = r_cnt;
    assign bound_reached[g] = r_pls;
    assign stopped[g]       = r_stp;
  end
endmodule

// File: tb/tb_multi_bounded_counter.sv
// tb_multi_bounded_counter: scoreboard bench driving a wrap-mode and a stop-mode instance with shared stimulus
module tb_multi_bounded_counter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  event_in = '0;
  logic [3:0]  enable = '1;
  logic [3:0]  clear = '0;
  logic [31:0] bound = '0;
  logic [31:0] cw, cs;
  logic [3:0]  pw, ps, sw, ss;
  int n_chk = 0;
  int n_pass = 0;
`ifdef MULTI_BOUNDED_COUNTER_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  typedef struct packed {
    logic [1:0][31:0] c;
    logic [1:0][3:0]  p;
    logic [1:0][3:0]  s;
  } exp_t;
  exp_t q[$];
  int  mc[2][4];
  bit  ms[2][4];
  bit  mp[4];
  bit  sy1[4], sy2[4];

  always #5 clk = ~clk;

  multi_bounded_counter #(.N(8), .NUM_CH(4), .WRAP_ON_BOUND(1)) u_wrap (
    .clk(clk), .reset(reset), .event_in(event_in), .enable(enable), .clear(clear),
    .bound(bound), .count(cw), .bound_reached(pw), .stopped(sw));
  multi_bounded_counter #(.N(8), .NUM_CH(4), .WRAP_ON_BOUND(0)) u_stop (
    .clk(clk), .reset(reset), .event_in(event_in), .enable(enable), .clear(clear),
    .bound(bound), .count(cs), .bound_reached(ps), .stopped(ss));

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      mc[0][c] = 0; mc[1][c] = 0; ms[0][c] = 0; ms[1][c] = 0;
      mp[c] = 1; sy1[c] = 1; sy2[c] = 1;
    end
  endtask

  // reference: evaluate the counting rules for this edge, queue the expected outputs, then advance one cycle
  task automatic tick();
    exp_t e;
    bit ev[4];
    e = '0;
    for (int c = 0; c < 4; c++) begin
      if (LAT == 2) begin
        ev[c] = sy2[c]; sy2[c] = sy1[c]; sy1[c] = event_in[c];
      end else ev[c] = event_in[c];
    end
    for (int w = 0; w < 2; w++)
      for (int c = 0; c < 4; c++) begin
        int b;
        b = int'(bound[c*8 +: 8]);
        if (clear[c]) begin
          mc[w][c] = 0; ms[w][c] = 0;
        end else if (ev[c] && !mp[c] && enable[c] && !ms[w][c] && b != 0) begin
          if (mc[w][c] + 1 >= b) begin
            e.p[w][c] = 1'b1;
            if (w == 0) mc[w][c] = 0;
            else begin mc[w][c] = b; ms[w][c] = 1; end
          end else mc[w][c] = mc[w][c] + 1;
        end
        e.c[w][c*8 +: 8] = 8'(mc[w][c]);
        e.s[w][c] = ms[w][c];
      end
    for (int c = 0; c < 4; c++) mp[c] = ev[c];
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic edges(int n, logic [3:0] m);
    for (int i = 0; i < n; i++) begin
      event_in = m; tick();
      event_in = '0; tick();
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_all();
    clear = '1; tick(); clear = '0;
  endtask

  // monitor: outputs are presented every cycle, compare against the oldest queued expectation
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("count_wrap", 64'(cw), 64'(e.c[0]));
      chk("count_stop", 64'(cs), 64'(e.c[1]));
      chk("pulse_wrap", 64'(pw), 64'(e.p[0]));
      chk("pulse_stop", 64'(ps), 64'(e.p[1]));
      chk("stopped_wrap", 64'(sw), 64'(e.s[0]));
      chk("stopped_stop", 64'(ss), 64'(e.s[1]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);
    chk("reset_counts", 64'({cw, cs}), 64'(0));
    // wrap: ch0 bound 3, others bound 5 with no events
    bound = {8'd5, 8'd5, 8'd5, 8'd3};
    edges(7, 4'b0001);
    idle(LAT + 1);
    chk("wrap7_ch0", 64'(cw[7:0]), 64'(1));
    chk("wrap7_ch1", 64'(cw[15:8]), 64'(0));
    chk("stop_ch0_at3", 64'(cs[7:0]), 64'(3));
    // stop: bound 5, 8 edges, then clear and one edge
    clear_all();
    bound = {4{8'd5}};
    edges(8, 4'b1111);
    idle(LAT + 1);
    chk("stop8_cnt", 64'(cs[7:0]), 64'(5));
    chk("stop8_flag", 64'(ss), 64'(4'hf));
    clear_all();
    edges(1, 4'b0001);
    idle(LAT + 1);
    chk("stop_clr_edge", 64'(cs[7:0]), 64'(1));
    // lowered bound
    clear_all();
    bound = {4{8'd10}};
    edges(6, 4'b0001);
    idle(LAT + 1);
    bound = {4{8'd4}};
    edges(1, 4'b0001);
    idle(LAT + 1);
    chk("lower_wrap", 64'(cw[7:0]), 64'(0));
    chk("lower_stop", 64'(cs[7:0]), 64'(4));
    // bound zero and disabled edges
    clear_all();
    bound = '0;
    edges(10, 4'b1111);
    bound = {4{8'd9}};
    enable = '0;
    edges(3, 4'b1111);
    idle(LAT + 1);
    enable = '1;
    chk("zero_dis_cnt", 64'({cw, cs}), 64'(0));
    // full-range bound
    bound = {4{8'd255}};
    edges(254, 4'b0001);
    idle(LAT + 1);
    chk("b255_254", 64'(cw[7:0]), 64'(254));
    edges(3, 4'b0001);
    idle(LAT + 1);
    chk("b255_stop", 64'(cs[7:0]), 64'(255));
    chk("b255_wrap", 64'(cw[7:0]), 64'(2));
    // clear coinciding with the hitting edge
    clear_all();
    bound = {4{8'd3}};
    edges(2, 4'b0001);
    event_in = 4'b0001;
    idle(LAT);
    clear = 4'b0001; tick(); clear = '0;
    event_in = '0;
    idle(LAT + 1);
    chk("clr_hit", 64'({cw[7:0], cs[7:0]}), 64'(0));
    // asynchronous reset mid-count, event held high across release
    bound = {4{8'd10}};
    edges(3, 4'b0001);
    idle(LAT + 1);
    chk("pre_reset", 64'(cw[7:0]), 64'(3));
    event_in = 4'b1111;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_cnt", 64'({cw, cs}), 64'(0));
    chk("async_rst_flags", 64'({pw, ps, sw, ss}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle(LAT + 3);
    chk("held_high", 64'({cw, cs}), 64'(0));
    edges(1, 4'b0000);
    edges(1, 4'b1111);
    idle(LAT + 1);
    chk("post_reset_edge", 64'(cw[7:0]), 64'(1));
    // randomized phase
    for (int i = 0; i < 2500; i++) begin
      if (i % 40 == 0)
        for (int c = 0; c < 4; c++)
          bound[c*8 +: 8] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      event_in = 4'($urandom);
      enable = 4'($urandom) | 4'($urandom);
      clear = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0;
      tick();
    end
    clear = '0;
    idle(2);
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
